// File: rtl/ras_pkg.sv
// ras_pkg
//   Shared definitions for the return-address stack: default sizes, the
//   stored address type, and the per-cycle operation decode.
//   Optional feature macro used by the slice: RAS_STATS_EN (statistics).
package ras_pkg;

  localparam int RAS_ADDR_W = 32;
  localparam int RAS_DEPTH  = 8;
  localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);

  typedef logic [RAS_ADDR_W-1:0] ras_addr_t;

  typedef enum logic [2:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP,
    RAS_FLUSH
  } ras_op_e;

  // Priority is Flush > Push+Pop > Push > Pop. A simultaneous push and pop
  // on an empty stack has nothing to replace, so it degrades to a plain push.
  function automatic ras_op_e ras_decode(input logic flush,
                                         input logic push,
                                         input logic pop,
                                         input logic nonEmpty);
    if (flush)                  return RAS_FLUSH;
    if (push && pop && nonEmpty) return RAS_SWAP;
    if (push)                   return RAS_PUSH;
    if (pop)                    return RAS_POP;
    return RAS_NOP;
  endfunction

endpackage

// File: rtl/ras_sat_counter.sv
// ras_sat_counter
//   Event counter that increments on inc_i and holds at all-ones.
//   Ports:
//     clk_i    rising-edge clock
//     rstn_i   asynchronous reset, active-low (clears the count)
//     inc_i    count one event this cycle
//     count_o  current count, CNT_W bits
module ras_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Stop at all-ones instead of wrapping back to zero.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack
//   Return-address stack beside the PC-select mux. Calls push the return
//   address (call PC+1); returns pop it and TopAddr is the predicted target.
//   Storage is a circular buffer: pushing when full overwrites the oldest entry.
//   Ports:
//     clk       rising-edge clock
//     rstn      asynchronous reset, active-low
//     Flush     pipeline redirect; empties the stack (entries are not cleared)
//     PushEn    call in IF; push PushAddr
//     PushAddr  return address to push
//     PopEn     return in IF; consume the top entry
//     TopAddr   current top entry, 0 when empty
//     TopValid  stack non-empty
//     Depth     occupancy 0..DEPTH
//     Full      Depth == DEPTH
//     Empty     Depth == 0
//   Optional (macro RAS_STATS_EN): StatPush, StatOvf, StatUdf saturating
//   counters of accepted pushes, overflows and underflows.
module ret_addr_stack
  import ras_pkg::*;
#(
  parameter int ADDR_W = RAS_ADDR_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     Flush,
  input  logic                     PushEn,
  input  logic [ADDR_W-1:0]        PushAddr,
  input  logic                     PopEn,
  output logic [ADDR_W-1:0]        TopAddr,
  output logic                     TopValid,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic                     Full,
  output logic                     Empty
`ifdef RAS_STATS_EN
  ,
  output logic [CNT_W-1:0]         StatPush,
  output logic [CNT_W-1:0]         StatOvf,
  output logic [CNT_W-1:0]         StatUdf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DEP_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  topPtr_q, topPtr_d;
  logic [DEP_W-1:0]  cnt_q, cnt_d;
  logic              memWe;
  logic [PTR_W-1:0]  memIdx;
  logic              isFull, isEmpty;
  ras_op_e           op;

  assign isFull  = (cnt_q == DEP_W'(DEPTH));
  assign isEmpty = (cnt_q == '0);
  assign op      = ras_decode(Flush, PushEn, PopEn, !isEmpty);

  // Next-state for pointer/count and the single memory write port. The
  // pointer wraps naturally in PTR_W bits, which gives the overwrite-oldest
  // behaviour on a full push without any extra logic.
  always_comb begin
    topPtr_d = topPtr_q;
    cnt_d    = cnt_q;
    memWe    = 1'b0;
    memIdx   = topPtr_q;
    unique case (op)
      RAS_FLUSH: begin
        topPtr_d = '0;
        cnt_d    = '0;
      end
      RAS_PUSH: begin
        topPtr_d = topPtr_q + PTR_W'(1);
        memWe    = 1'b1;
        memIdx   = topPtr_q + PTR_W'(1);
        if (!isFull) cnt_d = cnt_q + DEP_W'(1);
      end
      RAS_POP: begin
        if (!isEmpty) begin
          topPtr_d = topPtr_q - PTR_W'(1);
          cnt_d    = cnt_q - DEP_W'(1);
        end
      end
      RAS_SWAP: begin
        memWe  = 1'b1;
        memIdx = topPtr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      topPtr_q <= '0;
      cnt_q    <= '0;
    end else begin
      topPtr_q <= topPtr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (memWe) begin
      mem_q[memIdx] <= PushAddr;
    end
  end

  // No bypass from PushAddr: the top reflects registered state only.
  assign TopAddr  = isEmpty ? '0 : mem_q[topPtr_q];
  assign TopValid = !isEmpty;
  assign Depth    = cnt_q;
  assign Full     = isFull;
  assign Empty    = isEmpty;

`ifdef RAS_STATS_EN
  logic pushEvt, ovfEvt, udfEvt;

  // Flush cycles never reach PUSH/SWAP in the decode, and the underflow
  // term masks Flush explicitly, so flush-cycle events are not counted.
  assign pushEvt = (op == RAS_PUSH) || (op == RAS_SWAP);
  assign ovfEvt  = (op == RAS_PUSH) && isFull;
  assign udfEvt  = !Flush && PopEn && isEmpty;

  ras_sat_counter #(.CNT_W(CNT_W)) uStatPush (
    .clk_i(clk), .rstn_i(rstn), .inc_i(pushEvt), .count_o(StatPush));
  ras_sat_counter #(.CNT_W(CNT_W)) uStatOvf (
    .clk_i(clk), .rstn_i(rstn), .inc_i(ovfEvt), .count_o(StatOvf));
  ras_sat_counter #(.CNT_W(CNT_W)) uStatUdf (
    .clk_i(clk), .rstn_i(rstn), .inc_i(udfEvt), .count_o(StatUdf));
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack
//   Bench for ret_addr_stack: directed scenarios plus random traffic, all
//   compared against a queue-based model of the stack. Statistics outputs
//   are compared only when built with RAS_STATS_EN.
module tb_ret_addr_stack;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rstn;
  logic              Flush;
  logic              PushEn;
  logic [ADDR_W-1:0] PushAddr;
  logic              PopEn;
  logic [ADDR_W-1:0] TopAddr;
  logic              TopValid;
  logic [$clog2(DEPTH):0] Depth;
  logic              Full;
  logic              Empty;
`ifdef RAS_STATS_EN
  logic [CNT_W-1:0]  StatPush, StatOvf, StatUdf;
`endif

  ret_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .Flush(Flush), .PushEn(PushEn),
    .PushAddr(PushAddr), .PopEn(PopEn), .TopAddr(TopAddr),
    .TopValid(TopValid), .Depth(Depth), .Full(Full), .Empty(Empty)
`ifdef RAS_STATS_EN
    , .StatPush(StatPush), .StatOvf(StatOvf), .StatUdf(StatUdf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;

  // Reference model: youngest entry at the back of the queue.
  logic [ADDR_W-1:0] modelQ [$];
  int modelPush, modelOvf, modelUdf;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [ADDR_W-1:0] modelTop();
    if (modelQ.size() == 0) return '0;
    return modelQ[modelQ.size()-1];
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".TopAddr"},  64'(TopAddr),  64'(modelTop()));
    checkOutput({tag, ".TopValid"}, 64'(TopValid), 64'(modelQ.size() != 0));
    checkOutput({tag, ".Depth"},    64'(Depth),    64'(modelQ.size()));
    checkOutput({tag, ".Full"},     64'(Full),     64'(modelQ.size() == DEPTH));
    checkOutput({tag, ".Empty"},    64'(Empty),    64'(modelQ.size() == 0));
`ifdef RAS_STATS_EN
    checkOutput({tag, ".StatPush"}, 64'(StatPush), 64'(modelPush));
    checkOutput({tag, ".StatOvf"},  64'(StatOvf),  64'(modelOvf));
    checkOutput({tag, ".StatUdf"},  64'(StatUdf),  64'(modelUdf));
`endif
  endtask

  task automatic modelStep(input logic f, input logic pu,
                           input logic [ADDR_W-1:0] a, input logic po);
    if (f) begin
      modelQ.delete();
    end else if (pu && po && modelQ.size() > 0) begin
      modelQ[modelQ.size()-1] = a;
      modelPush++;
    end else if (pu) begin
      if (po) modelUdf++;
      if (modelQ.size() == DEPTH) begin
        void'(modelQ.pop_front());
        modelOvf++;
      end
      modelQ.push_back(a);
      modelPush++;
    end else if (po) begin
      if (modelQ.size() > 0) void'(modelQ.pop_back());
      else modelUdf++;
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, check the pre-edge
  // outputs (which depend only on registered state), clock, update model.
  task automatic applyStimulus(input logic f, input logic pu,
                               input logic [ADDR_W-1:0] a, input logic po);
    Flush = f; PushEn = pu; PushAddr = a; PopEn = po;
    compareAll("cyc");
    @(posedge clk);
    modelStep(f, pu, a, po);
    @(negedge clk);
    Flush = 1'b0; PushEn = 1'b0; PopEn = 1'b0; PushAddr = '0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    Flush = 1'b0; PushEn = 1'b0; PopEn = 1'b0; PushAddr = '0;
    repeat (2) @(negedge clk);
    modelQ.delete();
    modelPush = 0; modelOvf = 0; modelUdf = 0;
    rstn = 1'b1;
  endtask

  initial begin
    doReset();

    // Reset then idle
    checkOutput("rst.TopValid", 64'(TopValid), 64'd0);
    checkOutput("rst.Empty",    64'(Empty),    64'd1);
    checkOutput("rst.Depth",    64'(Depth),    64'd0);
    checkOutput("rst.TopAddr",  64'(TopAddr),  64'd0);
    applyStimulus(0, 0, '0, 0);
    compareAll("idle");

    // Push three, pop three: LIFO order visible in the pop cycles
    applyStimulus(0, 1, 32'h10, 0);
    applyStimulus(0, 1, 32'h20, 0);
    applyStimulus(0, 1, 32'h30, 0);
    checkOutput("lifo.pop1", 64'(TopAddr), 64'h30);
    applyStimulus(0, 0, '0, 1);
    checkOutput("lifo.pop2", 64'(TopAddr), 64'h20);
    applyStimulus(0, 0, '0, 1);
    checkOutput("lifo.pop3", 64'(TopAddr), 64'h10);
    applyStimulus(0, 0, '0, 1);
    checkOutput("lifo.empty", 64'(Empty), 64'd1);
    checkOutput("lifo.depth", 64'(Depth), 64'd0);

    // Overflow: nine pushes into eight entries, then drain past empty
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(0, 1, 32'(i), 0);
    checkOutput("ovf.Full",  64'(Full),  64'd1);
    checkOutput("ovf.Depth", 64'(Depth), 64'd8);
`ifdef RAS_STATS_EN
    checkOutput("ovf.StatOvf", 64'(StatOvf), 64'd1);
`endif
    for (int i = 9; i >= 2; i--) begin
      checkOutput("ovf.popVal", 64'(TopAddr), 64'(i));
      applyStimulus(0, 0, '0, 1);
    end
    applyStimulus(0, 0, '0, 1);
    checkOutput("udf.TopValid", 64'(TopValid), 64'd0);
`ifdef RAS_STATS_EN
    checkOutput("udf.StatUdf", 64'(StatUdf), 64'd1);
`endif

    // Simultaneous push and pop replaces the top
    doReset();
    applyStimulus(0, 1, 32'h40, 0);
    applyStimulus(0, 1, 32'h50, 0);
    applyStimulus(0, 1, 32'h60, 1);
    checkOutput("swap.TopAddr", 64'(TopAddr), 64'h60);
    checkOutput("swap.Depth",   64'(Depth),   64'd2);
    applyStimulus(0, 0, '0, 1);
    checkOutput("swap.under", 64'(TopAddr), 64'h40);

    // Push during Flush is ignored and not counted
    applyStimulus(1, 1, 32'h70, 0);
    checkOutput("flush.Empty", 64'(Empty), 64'd1);
`ifdef RAS_STATS_EN
    checkOutput("flush.StatPush", 64'(StatPush), 64'd3);
`endif

    // Asynchronous reset between edges with three entries held
    applyStimulus(0, 1, 32'hA1, 0);
    applyStimulus(0, 1, 32'hA2, 0);
    applyStimulus(0, 1, 32'hA3, 0);
    checkOutput("arst.pre", 64'(Depth), 64'd3);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst.Depth",    64'(Depth),    64'd0);
    checkOutput("arst.Empty",    64'(Empty),    64'd1);
    checkOutput("arst.TopValid", 64'(TopValid), 64'd0);
    checkOutput("arst.TopAddr",  64'(TopAddr),  64'd0);
    checkOutput("arst.Full",     64'(Full),     64'd0);
`ifdef RAS_STATS_EN
    checkOutput("arst.StatPush", 64'(StatPush), 64'd0);
`endif
    @(negedge clk);
    doReset();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    $urandom_range(0, 1) == 1,
                    $urandom,
                    $urandom_range(0, 1) == 1);
    end
    compareAll("final");

    $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
